meat_draw_scheduler: RTL
========================

// Module: meat_draw_scheduler
// PURPOSE
//  Shares the single VGA plot port between the N meat tiles of the grill.
//  Tracks which tiles need redrawing (colour change or reset), picks one, and
//  sweeps its pixel rectangle one pixel per accepted cycle.
//  Each pixel is fat-coloured on the tile border and muscle-coloured inside.
//  Sits between the per-tile colour controllers and the VGA adapter; replaces free-running tile muxing.
// PARAMETERS
//  N_TILES   6  number of meat tiles (requesters), 2..8
//  TILE_W    8  tile width in pixels, >=2
//  TILE_H    8  tile height in pixels, >=2
//  COLOUR_W  9  colour bus width
//  COORD_W   8  x/y coordinate width
// PORTS
//  clk           in   1                   clock
//  resetn        in   1                   reset, synchronous, active-low
//  dirty_req     in   N_TILES             per-tile redraw request pulse (1 cycle)
//  colour_fat    in   N_TILES*COLOUR_W    packed fat colours, tile i at [i*COLOUR_W +: COLOUR_W]
//  colour_muscle in   N_TILES*COLOUR_W    packed muscle colours, same packing
//  tile_x_base   in   N_TILES*COORD_W     packed tile origin x
//  tile_y_base   in   N_TILES*COORD_W     packed tile origin y
//  plot_ready    in   1                   VGA side accepts pixel this cycle
//  plot          out  1                   pixel valid
//  x_out         out  COORD_W             pixel x
//  y_out         out  COORD_W             pixel y
//  colour_out    out  COLOUR_W            pixel colour
//  tile_idx      out  3                   tile being drawn
//  busy          out  1                   high in LATCH/DRAW/DONE
//  tile_done     out  1                   1-cycle pulse after last pixel of a tile accepted
// BEHAVIOUR
//  - Reset: state IDLE; pending[] = all ones (full first draw); rr_ptr = N_TILES-1;
//    plot, busy, tile_done = 0; x_out, y_out, colour_out, tile_idx = 0; px = py = 0.
//  - pending[i] set on the cycle after dirty_req[i]=1, cleared when tile i enters LATCH.
//    If set and clear coincide, set wins.
//  - A request for the tile currently in DRAW re-arms pending; the tile is redrawn later.
//  - FSM IDLE -> LATCH when any pending bit is set.
//    Arbitration is round-robin: search starts at rr_ptr+1 mod N_TILES, first pending bit wins.
//    rr_ptr <= winner.
//  - LATCH (1 cycle): latch winner's fat, muscle, x_base, y_base into local regs; px = py = 0.
//    Input changes after LATCH do not affect the tile in progress (no tearing).
//  - DRAW: plot=1; x_out = x_base+px, y_out = y_base+py, both mod 2^COORD_W (wrap, no saturate).
//    colour_out = fat if px==0 | px==TILE_W-1 | py==0 | py==TILE_H-1, else muscle.
//    Advance only when plot_ready=1: px++ ; at px==TILE_W-1, px=0 and py++.
//    plot_ready=0 holds all outputs stable and plot stays 1.
//    Accepting (TILE_W-1, TILE_H-1) -> DONE.
//  - DONE (1 cycle): tile_done=1, plot=0; -> IDLE. IDLE re-arbitrates next cycle.
//  - Latency: dirty_req at cycle t (idle scheduler) -> LATCH at t+2 -> first plot at t+3.
//    With plot_ready tied high, one tile occupies TILE_W*TILE_H+2 cycles from LATCH to DONE, inclusive.
//  - plot=0 in IDLE/LATCH/DONE; x_out, y_out and colour_out hold their last values there.
//  - resetn low mid-DRAW: abort next edge, outputs to reset values, all tiles pending again.
// CONFIGURATION
//  - SCHED_FIXED_PRIO_EN defined: fixed priority, lowest pending index wins; rr_ptr unused.
//  - Not defined (default): round-robin as above.
// TESTING
//  1 Reset, plot_ready=1, no requests -> tiles 0..5 drawn in order; each 64 plots, tile_done x6, then idle.
//  2 Tile 2 base (10,20), fat=9'h1C0, muscle=9'h038, single request ->
//    plot (10,20)=1C0, (11,21)=038, last (17,27)=1C0.
//  3 Requests on 1 and 4 same cycle, rr_ptr=3 -> tile 4 first, then 1
//    (SCHED_FIXED_PRIO_EN: tile 1 first, then 4).
//  4 plot_ready low 5 cycles mid-tile -> x/y/colour frozen, plot held 1; total 64 accepted pixels, none skipped or repeated.
//  5 dirty_req[3] during tile 3 DRAW, colour changed -> current tile keeps old colour; tile 3 redrawn next with new colour.
//  6 Base x=252 -> x_out wraps 252..255,0..3; resetn low mid-DRAW -> plot=0 next cycle, redraw restarts at tile 0.

Source files
------------

// File: rtl/meat_draw_scheduler.sv
// meat_draw_scheduler
//   Shares the single VGA plot port between N_TILES meat tiles. Tiles that need
//   redrawing are marked pending; one is picked, its colours and origin are
//   latched, and its TILE_W x TILE_H rectangle is swept one pixel per accepted
//   cycle (fat colour on the border, muscle colour inside).
//
//   Build option: define SCHED_FIXED_PRIO_EN for fixed priority (lowest pending
//   index wins). Default build uses round-robin arbitration.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   i_dirty_req          per-tile redraw request pulses
//   i_colour_fat         packed fat colours, tile i at [i*COLOUR_W +: COLOUR_W]
//   i_colour_muscle      packed muscle colours, same packing
//   i_tile_x_base/y_base packed tile origins, tile i at [i*COORD_W +: COORD_W]
//   i_plot_ready         VGA side accepts the current pixel this cycle
//   o_plot               pixel valid (DRAW only)
//   o_x_out/o_y_out      pixel coordinate
//   o_colour_out         pixel colour
//   o_tile_idx           tile being drawn
//   o_busy               high while a tile is latched, drawn or finishing
//   o_tile_done          one-cycle pulse after the last pixel is accepted
module meat_draw_scheduler #(
    parameter int unsigned N_TILES  = 6,
    parameter int unsigned TILE_W   = 8,
    parameter int unsigned TILE_H   = 8,
    parameter int unsigned COLOUR_W = 9,
    parameter int unsigned COORD_W  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_TILES-1:0]            i_dirty_req,
    input  logic [N_TILES*COLOUR_W-1:0]   i_colour_fat,
    input  logic [N_TILES*COLOUR_W-1:0]   i_colour_muscle,
    input  logic [N_TILES*COORD_W-1:0]    i_tile_x_base,
    input  logic [N_TILES*COORD_W-1:0]    i_tile_y_base,
    input  logic                          i_plot_ready,
    output logic                          o_plot,
    output logic [COORD_W-1:0]            o_x_out,
    output logic [COORD_W-1:0]            o_y_out,
    output logic [COLOUR_W-1:0]           o_colour_out,
    output logic [2:0]                    o_tile_idx,
    output logic                          o_busy,
    output logic                          o_tile_done
);

    localparam int unsigned PX_W = $clog2(TILE_W);
    localparam int unsigned PY_W = $clog2(TILE_H);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(TILE_H - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StDraw, StDone} state_t;

    state_t              r_state, w_state_d;
    logic [N_TILES-1:0]  r_pending, w_pending_d, w_pending_clr;
    logic [2:0]          r_tile, w_tile_d;
    logic [PX_W-1:0]     r_px, w_px_d, w_px_n;
    logic [PY_W-1:0]     r_py, w_py_d, w_py_n;
    logic [COLOUR_W-1:0] r_fat, w_fat_d, r_muscle, w_muscle_d;
    logic [COORD_W-1:0]  r_x_base, w_x_base_d, r_y_base, w_y_base_d;
    logic [COORD_W-1:0]  r_x_out, w_x_out_d, r_y_out, w_y_out_d;
    logic [COLOUR_W-1:0] r_colour_out, w_colour_out_d;
    logic                w_any;
    logic [2:0]          w_winner;
`ifndef SCHED_FIXED_PRIO_EN
    logic [2:0]          r_rr_ptr, w_rr_ptr_d;
`endif

    // Arbitration: first pending tile in search order wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
`ifdef SCHED_FIXED_PRIO_EN
        for (int unsigned i = 0; i < N_TILES; i++) begin
            if (r_pending[i] && !w_any) begin
                w_any    = 1'b1;
                w_winner = 3'(i);
            end
        end
`else
        for (int unsigned k = 1; k <= N_TILES; k++) begin
            if (r_pending[(32'(r_rr_ptr) + k) % N_TILES] && !w_any) begin
                w_any    = 1'b1;
                w_winner = 3'((32'(r_rr_ptr) + k) % N_TILES);
            end
        end
`endif
    end

    // Coordinates of the pixel that follows the current one in raster order.
    always_comb begin
        if (r_px == PX_LAST) begin
            w_px_n = '0;
            w_py_n = r_py + 1'b1;
        end else begin
            w_px_n = r_px + 1'b1;
            w_py_n = r_py;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_pending_clr  = '0;
        w_tile_d       = r_tile;
        w_px_d         = r_px;
        w_py_d         = r_py;
        w_fat_d        = r_fat;
        w_muscle_d     = r_muscle;
        w_x_base_d     = r_x_base;
        w_y_base_d     = r_y_base;
        w_x_out_d      = r_x_out;
        w_y_out_d      = r_y_out;
        w_colour_out_d = r_colour_out;
`ifndef SCHED_FIXED_PRIO_EN
        w_rr_ptr_d     = r_rr_ptr;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_d     = StLatch;
                    w_tile_d      = w_winner;
                    w_pending_clr = N_TILES'(1) << w_winner;
`ifndef SCHED_FIXED_PRIO_EN
                    w_rr_ptr_d    = w_winner;
`endif
                end
            end
            StLatch: begin
                // Snapshot the tile's inputs so later changes cannot tear it.
                w_fat_d        = i_colour_fat[32'(r_tile)*COLOUR_W +: COLOUR_W];
                w_muscle_d     = i_colour_muscle[32'(r_tile)*COLOUR_W +: COLOUR_W];
                w_x_base_d     = i_tile_x_base[32'(r_tile)*COORD_W +: COORD_W];
                w_y_base_d     = i_tile_y_base[32'(r_tile)*COORD_W +: COORD_W];
                w_px_d         = '0;
                w_py_d         = '0;
                // Pixel (0,0) is always on the border.
                w_x_out_d      = w_x_base_d;
                w_y_out_d      = w_y_base_d;
                w_colour_out_d = w_fat_d;
                w_state_d      = StDraw;
            end
            StDraw: begin
                if (i_plot_ready) begin
                    if (r_px == PX_LAST && r_py == PY_LAST) begin
                        w_state_d = StDone;
                    end else begin
                        w_px_d    = w_px_n;
                        w_py_d    = w_py_n;
                        w_x_out_d = r_x_base + COORD_W'(w_px_n);
                        w_y_out_d = r_y_base + COORD_W'(w_py_n);
                        if (w_px_n == '0 || w_px_n == PX_LAST ||
                            w_py_n == '0 || w_py_n == PY_LAST) begin
                            w_colour_out_d = r_fat;
                        end else begin
                            w_colour_out_d = r_muscle;
                        end
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        // A new request on the same edge as the clear re-arms the tile.
        w_pending_d = (r_pending & ~w_pending_clr) | i_dirty_req;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_pending    <= '1;
            r_tile       <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_fat        <= '0;
            r_muscle     <= '0;
            r_x_base     <= '0;
            r_y_base     <= '0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_colour_out <= '0;
`ifndef SCHED_FIXED_PRIO_EN
            r_rr_ptr     <= 3'(N_TILES - 1);
`endif
        end else begin
            r_state      <= w_state_d;
            r_pending    <= w_pending_d;
            r_tile       <= w_tile_d;
            r_px         <= w_px_d;
            r_py         <= w_py_d;
            r_fat        <= w_fat_d;
            r_muscle     <= w_muscle_d;
            r_x_base     <= w_x_base_d;
            r_y_base     <= w_y_base_d;
            r_x_out      <= w_x_out_d;
            r_y_out      <= w_y_out_d;
            r_colour_out <= w_colour_out_d;
`ifndef SCHED_FIXED_PRIO_EN
            r_rr_ptr     <= w_rr_ptr_d;
`endif
        end
    end

    assign o_plot       = (r_state == StDraw);
    assign o_busy       = (r_state != StIdle);
    assign o_tile_done  = (r_state == StDone);
    assign o_x_out      = r_x_out;
    assign o_y_out      = r_y_out;
    assign o_colour_out = r_colour_out;
    assign o_tile_idx   = r_tile;

endmodule
